// File: rtl/if_stage_pkg.sv
// if_stage shared types and constants.
// State encoding, NOP word and the IF/ID bundle.
package if_stage_pkg;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  localparam int          XLEN         = 32;
  localparam logic [31:0] NOP          = 32'h0;
  localparam logic [31:0] PC_INC       = 32'd4;
  localparam logic [31:0] RESET_PC_DEF = 32'd100;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc4;
    logic            valid;
  } if_id_t;

  localparam if_id_t IF_ID_NOP = '{
    instr: NOP,
    pc4:   '0,
    valid: 1'b0
  };

endpackage

// File: rtl/if_stage_if.sv
// Fetch-stage bus: hazard/redirect controls, imem
// address/data and the IF/ID outputs toward decode.
interface if_stage_if #(
  parameter int DW = 32
);

  logic          stall;
  logic          flush;
  logic          redirect_valid;
  logic [DW-1:0] redirect_pc;
  logic [DW-1:0] pc_out;
  logic [DW-1:0] imem_in;
  logic [DW-1:0] ifid_instr;
  logic [DW-1:0] ifid_pc4;
  logic          ifid_valid;
  logic          fetch_fault;

  modport master (
    input  stall,
    input  flush,
    input  redirect_valid,
    input  redirect_pc,
    input  imem_in,
    output pc_out,
    output ifid_instr,
    output ifid_pc4,
    output ifid_valid,
    output fetch_fault
  );

  modport slave (
    output stall,
    output flush,
    output redirect_valid,
    output redirect_pc,
    output imem_in,
    input  pc_out,
    input  ifid_instr,
    input  ifid_pc4,
    input  ifid_valid,
    input  fetch_fault
  );

endinterface

// File: rtl/if_stage_if_id_reg.sv
// IF/ID pipeline register.
// Squash beats hold, hold beats load, else NOP.
module if_stage_if_id_reg
  import if_stage_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  input  logic   squash,
  input  logic   hold,
  input  logic   load,
  input  if_id_t d,
  output if_id_t q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= IF_ID_NOP;
    end else begin
      priority case (1'b1)
        squash:  q <= IF_ID_NOP;
        hold:    q <= q;
        load:    q <= d;
        default: q <= IF_ID_NOP;
      endcase
    end
  end

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: PC register, BOOT/RUN/HALT
// control and the IF/ID register feeding decode.
module if_stage
  import if_stage_pkg::*;
#(
  parameter int            DW       = 32,
  parameter logic [DW-1:0] RESET_PC = DW'(RESET_PC_DEF),
  parameter logic [DW-1:0] IMEM_HI  = DW'(128)
) (
  input  logic       clk,
  input  logic       reset_n,
  if_stage_if.master bus
);

  state_t        state_q;
  state_t        state_d;
  logic [DW-1:0] pc_q;
  logic [DW-1:0] pc_d;
  logic          fault_q;
  logic          fault_d;
  logic [DW-1:0] pc_next;
  logic          misaligned;
  logic          end_of_image;
  if_id_t        ifid_d;
  if_id_t        ifid_q;

  assign pc_next      = pc_q + DW'(PC_INC);
  assign misaligned   = |bus.redirect_pc[1:0];
  assign end_of_image = pc_next > IMEM_HI;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      fault_q <= fault_d;
    end
  end

  // A redirect is honoured from any state; a bad
  // target parks the stage in HALT with PC frozen.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    fault_d = fault_q;
    if (bus.redirect_valid) begin
      if (misaligned) begin
        fault_d = 1'b1;
        state_d = HALT;
      end else begin
        pc_d    = bus.redirect_pc;
        state_d = RUN;
      end
    end else begin
      unique case (state_q)
        BOOT: begin
          if (!bus.stall) state_d = RUN;
        end
        RUN: begin
          if (!bus.stall) begin
            pc_d = pc_next;
            if (end_of_image) state_d = HALT;
          end
        end
        HALT: begin
          state_d = HALT;
        end
        default: begin
          state_d = BOOT;
        end
      endcase
    end
  end

  assign ifid_d = '{
    instr: bus.imem_in,
    pc4:   pc_next,
    valid: 1'b1
  };

  if_stage_if_id_reg u_if_id (
    .clk    (clk),
    .rst_n  (reset_n),
    .squash (bus.flush | bus.redirect_valid),
    .hold   (bus.stall),
    .load   (state_q == RUN),
    .d      (ifid_d),
    .q      (ifid_q)
  );

  assign bus.pc_out      = pc_q;
  assign bus.ifid_instr  = ifid_q.instr;
  assign bus.ifid_pc4    = ifid_q.pc4;
  assign bus.ifid_valid  = ifid_q.valid;
  assign bus.fetch_fault = fault_q;

endmodule

// File: tb/tb_if_stage.sv
// Scoreboard bench for if_stage: directed steps push
// expected snapshots, a negedge monitor pops and compares.
module tb_if_stage;

  localparam logic [31:0] W0 = 32'h00221820;
  localparam logic [31:0] W1 = 32'h01232022;
  localparam logic [31:0] W2 = 32'h00692825;
  localparam logic [31:0] W3 = 32'h00693026;
  localparam logic [31:0] W4 = 32'h00693824;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        valid;
    logic        fault;
  } snap_t;

  logic clk;
  logic reset_n;
  int   checks;
  int   errors;

  snap_t exp_q[$];
  string name_q[$];

  if_stage_if #(.DW(32)) bus ();

  if_stage dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  function automatic logic [31:0] imem(input logic [31:0] a);
    case (a)
      32'd100, 32'd104,
      32'd108, 32'd112: imem = W0;
      32'd116:          imem = W1;
      32'd120:          imem = W2;
      32'd124:          imem = W3;
      32'd128:          imem = W4;
      default:          imem = 32'h0;
    endcase
  endfunction

  assign bus.imem_in = imem(bus.pc_out);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic push(input string n, input logic [31:0] pc,
                      input logic [31:0] instr, input logic [31:0] pc4,
                      input logic v, input logic f);
    snap_t s;
    s.pc    = pc;
    s.instr = instr;
    s.pc4   = pc4;
    s.valid = v;
    s.fault = f;
    exp_q.push_back(s);
    name_q.push_back(n);
  endtask

  task automatic step(input string n, input logic [31:0] pc,
                      input logic [31:0] instr, input logic [31:0] pc4,
                      input logic v, input logic f);
    @(posedge clk);
    #1;
    push(n, pc, instr, pc4, v, f);
  endtask

  task automatic set(input logic s, input logic fl,
                     input logic rv, input logic [31:0] rpc);
    bus.stall          = s;
    bus.flush          = fl;
    bus.redirect_valid = rv;
    bus.redirect_pc    = rpc;
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      snap_t e;
      snap_t g;
      string n;
      e = exp_q.pop_front();
      n = name_q.pop_front();
      g.pc    = bus.pc_out;
      g.instr = bus.ifid_instr;
      g.pc4   = bus.ifid_pc4;
      g.valid = bus.ifid_valid;
      g.fault = bus.fetch_fault;
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL %s: got pc=%0d instr=%h pc4=%0d v=%b f=%b, exp pc=%0d instr=%h pc4=%0d v=%b f=%b",
                 n, g.pc, g.instr, g.pc4, g.valid, g.fault,
                 e.pc, e.instr, e.pc4, e.valid, e.fault);
      end
    end
  end

  initial begin
    checks  = 0;
    errors  = 0;
    reset_n = 1'b0;
    set(0, 0, 0, 0);
    @(posedge clk);
    #1;
    push("reset", 100, 0, 0, 0, 0);
    reset_n = 1'b1;

    step("boot", 100, 0, 0, 0, 0);
    step("fetch100", 104, W0, 104, 1, 0);
    step("fetch104", 108, W0, 108, 1, 0);
    step("fetch108", 112, W0, 112, 1, 0);
    step("fetch112", 116, W0, 116, 1, 0);
    step("fetch116", 120, W1, 120, 1, 0);
    step("fetch120", 124, W2, 124, 1, 0);
    step("fetch124", 128, W3, 128, 1, 0);
    step("fetch128_end", 132, W4, 132, 1, 0);
    step("halt0", 132, 0, 0, 0, 0);
    step("halt1", 132, 0, 0, 0, 0);

    set(0, 0, 1, 100);
    step("halt_exit", 100, 0, 0, 0, 0);
    set(0, 0, 0, 0);
    step("rerun100", 104, W0, 104, 1, 0);
    step("rerun104", 108, W0, 108, 1, 0);
    step("rerun108", 112, W0, 112, 1, 0);
    step("rerun112", 116, W0, 116, 1, 0);

    set(1, 0, 0, 0);
    step("stall0", 116, W0, 116, 1, 0);
    step("stall1", 116, W0, 116, 1, 0);
    set(0, 0, 0, 0);
    step("unstall", 120, W1, 120, 1, 0);
    step("run120", 124, W2, 124, 1, 0);

    set(0, 0, 1, 116);
    step("redir116", 116, 0, 0, 0, 0);
    set(0, 0, 0, 0);
    step("after_redir", 120, W1, 120, 1, 0);

    set(1, 1, 0, 0);
    step("flush_stall", 120, 0, 0, 0, 0);
    set(0, 0, 0, 0);
    step("post_flush_stall", 124, W2, 124, 1, 0);

    set(0, 1, 0, 0);
    step("flush_only", 128, 0, 0, 0, 0);
    set(0, 0, 0, 0);
    step("last_word", 132, W4, 132, 1, 0);

    set(0, 0, 1, 100);
    step("exit2", 100, 0, 0, 0, 0);
    set(0, 0, 0, 0);
    step("r2_fetch100", 104, W0, 104, 1, 0);

    set(0, 0, 1, 118);
    step("misalign", 104, 0, 0, 0, 1);
    set(0, 0, 0, 0);
    step("fault_halt", 104, 0, 0, 0, 1);

    set(0, 0, 1, 100);
    step("fault_exit", 100, 0, 0, 0, 1);
    set(0, 0, 0, 0);
    step("f100", 104, W0, 104, 1, 1);
    step("f104", 108, W0, 108, 1, 1);
    step("f108", 112, W0, 112, 1, 1);
    step("f112", 116, W0, 116, 1, 1);
    step("f116", 120, W1, 120, 1, 1);

    @(negedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    push("async_reset", 100, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    step("boot2", 100, 0, 0, 0, 0);
    step("fetch2", 104, W0, 104, 1, 0);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
      @(negedge clk);
    end
    #1;
    checks++;
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain: got %0d pending, exp 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
